// File: rtl/cardio_feature_packer_if.sv
// Stream bundle for the cardio feature packer.
// Carries: s_valid/s_ready/s_data/s_last in, m_valid/m_ready/m_data out, err_len pulse.
interface cardio_feature_packer_if #(
    parameter int N_FEAT = 21,
    parameter int IN_W   = 8,
    parameter int Q_W    = 4
);
    logic                    s_valid;
    logic                    s_ready;
    logic [IN_W-1:0]         s_data;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [N_FEAT*Q_W-1:0]   m_data;
    logic                    err_len;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, err_len
    );
endinterface

// File: rtl/cardio_feature_packer.sv
// Quantizes raw features (saturating shift) and packs N_FEAT of them per frame.
// Ports: clk, rst (async high), bus (slave: feature stream in, packed frame out, err_len).
module cardio_feature_packer #(
    parameter int N_FEAT = 21,
    parameter int IN_W   = 8,
    parameter int Q_W    = 4,
    parameter int SHIFT  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    cardio_feature_packer_if.slave bus
);
    localparam int DW    = N_FEAT * Q_W;
    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IN_W-1:0] QMAX = IN_W'((1 << Q_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t          state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]   asm_q, asm_d;
    logic [DW-1:0]   md_q, md_d;
    logic            mv_q, mv_d;
    logic            err_q, err_d;

    logic [IN_W-1:0] shifted;
    logic [Q_W-1:0]  q;
    logic [DW-1:0]   asm_wr;
    logic            accept;
    logic            last_slot;
    logic            out_free;

    assign shifted   = bus.s_data >> SHIFT;
    assign q         = (shifted > QMAX) ? QMAX[Q_W-1:0] : shifted[Q_W-1:0];
    assign accept    = bus.s_valid && (state_q == FILL);
    assign last_slot = (idx_q == LAST_IDX);
    assign out_free  = !mv_q || bus.m_ready;

    always_comb begin
        asm_wr = asm_q;
        asm_wr[idx_q*Q_W +: Q_W] = q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        md_d    = md_q;
        mv_d    = mv_q;
        err_d   = 1'b0;
        if (mv_q && bus.m_ready) begin
            mv_d = 1'b0;
        end
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (!last_slot) begin
                        if (bus.s_last) begin
                            // short frame: drop what was gathered
                            idx_d = '0;
                            asm_d = '0;
                            err_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            asm_d = asm_wr;
                        end
                    end else begin
                        idx_d = '0;
                        err_d = !bus.s_last;
                        if (out_free) begin
                            md_d  = asm_wr;
                            mv_d  = 1'b1;
                            asm_d = '0;
                        end else begin
                            // park the finished frame until the output drains
                            asm_d   = asm_wr;
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (bus.m_ready) begin
                    md_d    = asm_q;
                    mv_d    = 1'b1;
                    asm_d   = '0;
                    state_d = FILL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            asm_q   <= '0;
            md_q    <= '0;
            mv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            md_q    <= md_d;
            mv_q    <= mv_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready = (state_q == FILL);
    assign bus.m_valid = mv_q;
    assign bus.m_data  = md_q;
    assign bus.err_len = err_q;
endmodule

// File: tb/tb_cardio_feature_packer.sv
// Bench for cardio_feature_packer: SHIFT=4 and SHIFT=2 instances in lockstep.
// Expected frames are queued at stimulus time and matched against handshaken output.
module tb_cardio_feature_packer;
    localparam int N  = 21;
    localparam int QW = 4;
    localparam int DW = N * QW;
    localparam int W2 = 2 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cardio_feature_packer_if #(.N_FEAT(N), .IN_W(8), .Q_W(QW)) bus4 ();
    cardio_feature_packer_if #(.N_FEAT(N), .IN_W(8), .Q_W(QW)) bus2 ();

    assign bus2.s_valid = bus4.s_valid;
    assign bus2.s_data  = bus4.s_data;
    assign bus2.s_last  = bus4.s_last;
    assign bus2.m_ready = bus4.m_ready;

    cardio_feature_packer #(.N_FEAT(N), .IN_W(8), .Q_W(QW), .SHIFT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    cardio_feature_packer #(.N_FEAT(N), .IN_W(8), .Q_W(QW), .SHIFT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic [W2-1:0] exp_q[$];
    logic [W2-1:0] obs_q[$];
    int rd      = 0;
    int err_cnt = 0;
    int checks  = 0;
    int errors  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus4.m_valid && bus4.m_ready)
                obs_q.push_back({bus4.m_data, bus2.m_data});
            if (bus4.err_len)
                err_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int mode, input int k);
        case (mode)
            0:       return 8'((k % 6) * 16);
            1:       return 8'hFF;
            2:       return 8'h3C;
            3:       return 8'h20;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [3:0] qz(input logic [7:0] d, input int sh);
        logic [7:0] v;
        v = d >> sh;
        return (v > 8'd15) ? 4'hF : v[3:0];
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit ok;
        bus4.s_valid = 1'b1;
        bus4.s_data  = d;
        bus4.s_last  = last;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus4.s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL beat_timeout s_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        bus4.s_valid = 1'b0;
        bus4.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int n, input int last_at, input bit push);
        logic [DW-1:0] e4, e2;
        logic [7:0] d;
        e4 = '0;
        e2 = '0;
        for (int k = 0; k < n; k++) begin
            d = pat(mode, k);
            e4[k*QW +: QW] = qz(d, 4);
            e2[k*QW +: QW] = qz(d, 2);
            if (push && k == n - 1)
                exp_q.push_back({e4, e2});
            send_beat(d, k == last_at);
        end
    endtask

    task automatic test_reset;
        bus4.s_valid = 1'b0;
        bus4.s_data  = '0;
        bus4.s_last  = 1'b0;
        bus4.m_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus4.s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_s_ready got=%b required 1", bus4.s_ready);
        end
        checks++;
        if (bus4.m_valid !== 1'b0) begin
            errors++; $display("FAIL rst_m_valid got=%b required 0", bus4.m_valid);
        end
        checks++;
        if ({bus4.m_data, bus2.m_data} !== '0) begin
            errors++; $display("FAIL rst_m_data got=%h required 0", bus4.m_data);
        end
        checks++;
        if (bus4.err_len !== 1'b0) begin
            errors++; $display("FAIL rst_err_len got=%b required 0", bus4.err_len);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pattern;
        logic [DW-1:0] ref_v;
        logic [W2-1:0] e;
        int e0;
        e0 = err_cnt;
        bus4.m_ready = 1'b1;
        for (int k = 0; k < N; k++) ref_v[k*QW +: QW] = 4'(k % 6);
        send_frame(0, N, N - 1, 1);
        checks++;
        if (bus4.m_valid !== 1'b1) begin
            errors++; $display("FAIL t1_latency m_valid=%b required 1", bus4.m_valid);
        end
        checks++;
        if (bus4.m_data !== ref_v) begin
            errors++; $display("FAIL t1_nibbles got=%h required %h", bus4.m_data, ref_v);
        end
        repeat (3) @(posedge clk);
        #1;
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t1_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t1_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL t1_missing pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (err_cnt != e0) begin
            errors++; $display("FAIL t1_err_len pulses=%0d required 0", err_cnt - e0);
        end
    endtask

    task automatic test_saturation;
        logic [W2-1:0] e;
        logic [DW-1:0] all_f, all_8;
        all_f = {N{4'hF}};
        all_8 = {N{4'h8}};
        bus4.m_ready = 1'b1;
        send_frame(1, N, N - 1, 1);
        checks++;
        if (bus2.m_data !== all_f || bus4.m_data !== all_f) begin
            errors++; $display("FAIL t2_ff got=%h/%h required %h", bus2.m_data, bus4.m_data, all_f);
        end
        send_frame(2, N, N - 1, 1);
        checks++;
        if (bus2.m_data !== all_f) begin
            errors++; $display("FAIL t2_3c got=%h required %h", bus2.m_data, all_f);
        end
        send_frame(3, N, N - 1, 1);
        checks++;
        if (bus2.m_data !== all_8) begin
            errors++; $display("FAIL t2_20 got=%h required %h", bus2.m_data, all_8);
        end
        repeat (3) @(posedge clk);
        #1;
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t2_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t2_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL t2_missing pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [W2-1:0] e;
        bus4.m_ready = 1'b0;
        send_frame(4, N, N - 1, 1);
        checks++;
        if (bus4.m_valid !== 1'b1 || {bus4.m_data, bus2.m_data} !== exp_q[0]) begin
            errors++; $display("FAIL t3_frame1 m_valid=%b got=%h", bus4.m_valid, bus4.m_data);
        end
        send_frame(4, N, N - 1, 1);
        checks++;
        if (bus4.s_ready !== 1'b0) begin
            errors++; $display("FAIL t3_full s_ready=%b required 0", bus4.s_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus4.s_ready !== 1'b0 || {bus4.m_data, bus2.m_data} !== exp_q[0]) begin
            errors++; $display("FAIL t3_hold s_ready=%b got=%h", bus4.s_ready, bus4.m_data);
        end
        bus4.m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.s_ready !== 1'b0) begin
            errors++; $display("FAIL t3_drain_cycle s_ready=%b required 0", bus4.s_ready);
        end
        @(posedge clk);
        #1;
        bus4.m_ready = 1'b0;
        checks++;
        if (bus4.m_valid !== 1'b1 || {bus4.m_data, bus2.m_data} !== exp_q[1]) begin
            errors++; $display("FAIL t3_frame2 m_valid=%b got=%h", bus4.m_valid, bus4.m_data);
        end
        checks++;
        if (bus4.s_ready !== 1'b1) begin
            errors++; $display("FAIL t3_s_ready_back got=%b required 1", bus4.s_ready);
        end
        bus4.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus4.m_valid !== 1'b0) begin
            errors++; $display("FAIL t3_m_valid_drop got=%b required 0", bus4.m_valid);
        end
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t3_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t3_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL t3_missing pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_early_last;
        logic [W2-1:0] e;
        int e0, n0;
        e0 = err_cnt;
        n0 = obs_q.size();
        bus4.m_ready = 1'b1;
        send_frame(4, 10, 9, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != e0 + 1) begin
            errors++; $display("FAIL t4_err_pulse got=%0d required 1", err_cnt - e0);
        end
        checks++;
        if (obs_q.size() != n0 || bus4.m_valid !== 1'b0) begin
            errors++; $display("FAIL t4_no_frame frames=%0d required 0", obs_q.size() - n0);
        end
        send_frame(4, N, N - 1, 1);
        repeat (3) @(posedge clk);
        #1;
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t4_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t4_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0 || err_cnt != e0 + 1) begin
            errors++; $display("FAIL t4_after pending=%0d errs=%0d required 0/1", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_missing_last;
        logic [W2-1:0] e;
        int e0;
        e0 = err_cnt;
        bus4.m_ready = 1'b1;
        send_frame(4, N, -1, 1);
        checks++;
        if (bus4.m_valid !== 1'b1 || bus4.err_len !== 1'b1) begin
            errors++; $display("FAIL t5_coincide m_valid=%b err_len=%b required 1/1", bus4.m_valid, bus4.err_len);
        end
        repeat (3) @(posedge clk);
        #1;
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t5_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t5_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0 || err_cnt != e0 + 1) begin
            errors++; $display("FAIL t5_after pending=%0d errs=%0d required 0/1", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        logic [W2-1:0] e;
        bus4.m_ready = 1'b0;
        send_frame(4, N, N - 1, 0);
        send_frame(4, 14, -1, 0);
        bus4.s_valid = 1'b1;
        bus4.s_data  = 8'hA5;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus4.m_valid !== 1'b0 || bus4.s_ready !== 1'b1 || bus4.m_data !== '0) begin
            errors++; $display("FAIL t6_rst_mid m_valid=%b s_ready=%b m_data=%h required 0/1/0", bus4.m_valid, bus4.s_ready, bus4.m_data);
        end
        bus4.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(4, N, N - 1, 0);
        send_frame(4, N, N - 1, 0);
        checks++;
        if (bus4.s_ready !== 1'b0) begin
            errors++; $display("FAIL t6_full_pre s_ready=%b required 0", bus4.s_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus4.m_valid !== 1'b0 || bus4.s_ready !== 1'b1 || bus4.m_data !== '0) begin
            errors++; $display("FAIL t6_rst_full m_valid=%b s_ready=%b m_data=%h required 0/1/0", bus4.m_valid, bus4.s_ready, bus4.m_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.m_ready = 1'b1;
        send_frame(4, N, N - 1, 1);
        checks++;
        if (bus4.m_valid !== 1'b1 || {bus4.m_data, bus2.m_data} !== exp_q[0]) begin
            errors++; $display("FAIL t6_slot0 m_valid=%b got=%h", bus4.m_valid, bus4.m_data);
        end
        repeat (3) @(posedge clk);
        #1;
        while (rd < obs_q.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL t6_extra_frame got=%h required none", obs_q[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_q[rd] !== e) begin
                    errors++; $display("FAIL t6_frame got=%h required %h", obs_q[rd], e);
                end
            end
            rd++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL t6_missing pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_pattern;
        test_saturation;
        test_backpressure;
        test_early_last;
        test_missing_last;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
